// File: rtl/dmem_req_ctrl_if.sv
// rtl/dmem_req_ctrl_if.sv - request/memory/status bundle for dmem_req_ctrl
//
// Ports (signals):
//   req_rd, req_wr, req_addr, req_data  : level-held request from EX/MEM
//   mem_done, mem_stall, mem_hit,
//   mem_rdata, mem_err                  : status and read data from mem_system
//   mem_addr, mem_wdata, mem_rd, mem_wr : command to mem_system
//   rd_data, stall_pipe, err,
//   acc_cnt, hit_cnt                    : results back to the pipeline
// Modports: slave = controller side, master = pipeline plus mem_system side.

interface dmem_req_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             req_rd;
    logic             req_wr;
    logic [15:0]      req_addr;
    logic [15:0]      req_data;
    logic             mem_done;
    logic             mem_stall;
    logic             mem_hit;
    logic [15:0]      mem_rdata;
    logic             mem_err;
    logic [15:0]      mem_addr;
    logic [15:0]      mem_wdata;
    logic             mem_rd;
    logic             mem_wr;
    logic [15:0]      rd_data;
    logic             stall_pipe;
    logic             err;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] hit_cnt;

    modport slave (
        input  req_rd, req_wr, req_addr, req_data,
        input  mem_done, mem_stall, mem_hit, mem_rdata, mem_err,
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        output rd_data, stall_pipe, err, acc_cnt, hit_cnt
    );

    modport master (
        output req_rd, req_wr, req_addr, req_data,
        output mem_done, mem_stall, mem_hit, mem_rdata, mem_err,
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        input  rd_data, stall_pipe, err, acc_cnt, hit_cnt
    );
endinterface

// File: rtl/dmem_req_ctrl.sv
// rtl/dmem_req_ctrl.sv - MEM-stage request controller in front of mem_system
//
// Converts a level-held load/store request into a single-cycle Rd/Wr pulse,
// waits for Done, latches load data, stalls the pipeline for the access and
// keeps a sticky error plus saturating access/hit counters.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : dmem_req_ctrl_if.slave (request in, mem_system command/status,
//          rd_data, stall_pipe, err, acc_cnt, hit_cnt out)

module dmem_req_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    dmem_req_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        COMPLETE = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [7:0]       WD_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    logic [15:0]      addr_q;
    logic [15:0]      data_q;
    logic             is_wr_q;
    logic [15:0]      rd_data_q;
    logic             err_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] hit_q;
    logic [7:0]       wd_q;

    logic req_any;
    logic req_bad;
    logic issue;

    assign req_any = bus.req_rd | bus.req_wr;
    assign req_bad = (bus.req_rd & bus.req_wr) | (req_any & bus.req_addr[0]);

    // The pulse is issued in the same cycle the request is seen in IDLE, so
    // a hit costs only two stalled cycles. A memory error or a reset in that
    // cycle suppresses it.
    assign issue = (state == IDLE) && !rst && !bus.mem_err && req_any
                   && !req_bad && !bus.mem_stall;

    assign bus.mem_rd    = issue & bus.req_rd;
    assign bus.mem_wr    = issue & bus.req_wr;
    assign bus.mem_addr  = (state == IDLE) ? bus.req_addr : addr_q;
    assign bus.mem_wdata = (state == IDLE) ? bus.req_data : data_q;

    always_comb begin
        bus.stall_pipe = 1'b1;
        case (state)
            IDLE:     bus.stall_pipe = req_any;
            COMPLETE: bus.stall_pipe = 1'b0;
            default:  bus.stall_pipe = 1'b1;
        endcase
    end

    assign bus.rd_data = rd_data_q;
    assign bus.err     = err_q;
    assign bus.acc_cnt = acc_q;
    assign bus.hit_cnt = hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            is_wr_q   <= 1'b0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            acc_q     <= '0;
            hit_q     <= '0;
            wd_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_err || req_bad) begin
                        err_q <= 1'b1;
                        state <= HALT;
                    end else if (issue) begin
                        addr_q  <= bus.req_addr;
                        data_q  <= bus.req_data;
                        is_wr_q <= bus.req_wr;
                        wd_q    <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // Error beats Done; a completing access beats the watchdog.
                    if (bus.mem_err) begin
                        err_q <= 1'b1;
                        state <= HALT;
                    end else if (bus.mem_done) begin
                        if (!is_wr_q) begin
                            rd_data_q <= bus.mem_rdata;
                        end
                        if (acc_q != CNT_MAX) begin
                            acc_q <= acc_q + 1'b1;
                        end
                        if (bus.mem_hit && (hit_q != CNT_MAX)) begin
                            hit_q <= hit_q + 1'b1;
                        end
                        wd_q  <= '0;
                        state <= COMPLETE;
                    end else if (wd_q == WD_LAST) begin
                        err_q <= 1'b1;
                        state <= HALT;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                COMPLETE: begin
                    if (bus.mem_err) begin
                        err_q <= 1'b1;
                        state <= HALT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb/tb_dmem_req_ctrl.sv - self-checking bench for dmem_req_ctrl

module tb_dmem_req_ctrl;

    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 64;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_req_ctrl_if #(.CNT_W(CNT_W)) bus ();

    dmem_req_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference: what the pipeline expects to see
    logic [15:0] ref_mem [logic [15:0]];
    // behavioural mem_system storage, filled only from what the DUT sends
    logic [15:0] sys_mem [logic [15:0]];
    int          exp_acc;
    int          exp_hit;
    logic [15:0] exp_rd;
    int          exp_rd_pulses;
    int          exp_wr_pulses;
    int          rd_pulses;
    int          wr_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] sys_read(input logic [15:0] a);
        if (sys_mem.exists(a)) return sys_mem[a];
        return a ^ 16'hA5C3;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            rd_pulses += int'(bus.mem_rd);
            wr_pulses += int'(bus.mem_wr);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst           = 1'b1;
        bus.req_rd    = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.mem_done  = 1'b0;
        bus.mem_stall = 1'b0;
        bus.mem_hit   = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_err   = 1'b0;
        next_cycle();
        next_cycle();
        rst     = 1'b0;
        exp_acc = 0;
        exp_hit = 0;
        exp_rd  = '0;
    endtask

    // One complete access: optional mem_stall cycles, the issue cycle, lat
    // WAIT cycles (Done on the last) and the COMPLETE cycle. Entered and left
    // one time unit after a rising edge with the controller idle.
    task automatic do_access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                             input int stalls, input int lat, input bit hit);
        bus.req_rd   = !wr;
        bus.req_wr   = wr;
        bus.req_addr = a;
        bus.req_data = d;
        for (int i = 0; i < stalls; i++) begin
            bus.mem_stall = 1'b1;
            @(negedge clk);
            check("memstall_nopulse", {bus.mem_rd, bus.mem_wr}, 0);
            check("memstall_stall", bus.stall_pipe, 1);
            next_cycle();
        end
        bus.mem_stall = 1'b0;
        @(negedge clk);
        check("issue_pulse", {bus.mem_rd, bus.mem_wr}, wr ? 2'b01 : 2'b10);
        check("issue_addr", bus.mem_addr, a);
        check("issue_stall", bus.stall_pipe, 1);
        if (wr) exp_wr_pulses++; else exp_rd_pulses++;
        next_cycle();
        for (int c = 1; c <= lat; c++) begin
            if (c == lat) begin
                bus.req_addr  = a;
                bus.req_data  = d;
                bus.mem_done  = 1'b1;
                bus.mem_hit   = hit;
                bus.mem_rdata = wr ? 16'($urandom) : sys_read(bus.mem_addr);
            end else begin
                bus.req_addr  = 16'($urandom);
                bus.req_data  = 16'($urandom);
                bus.mem_hit   = 1'($urandom);
                bus.mem_rdata = 16'($urandom);
            end
            @(negedge clk);
            check("wait_nopulse", {bus.mem_rd, bus.mem_wr}, 0);
            check("wait_stall", bus.stall_pipe, 1);
            check("wait_addr", bus.mem_addr, a);
            if (wr && c == lat) begin
                check("wait_wdata", bus.mem_wdata, d);
                sys_mem[bus.mem_addr] = bus.mem_wdata;
            end
            next_cycle();
        end
        bus.mem_done  = 1'b0;
        bus.mem_hit   = 1'b0;
        bus.mem_rdata = 16'($urandom);
        if (wr) ref_mem[a] = d;
        else    exp_rd = ref_read(a);
        exp_acc = (exp_acc < CMAX) ? exp_acc + 1 : CMAX;
        if (hit) exp_hit = (exp_hit < CMAX) ? exp_hit + 1 : CMAX;
        @(negedge clk);
        check("cmpl_stall", bus.stall_pipe, 0);
        check("cmpl_nopulse", {bus.mem_rd, bus.mem_wr}, 0);
        check("rd_data", bus.rd_data, exp_rd);
        check("acc_cnt", bus.acc_cnt, exp_acc);
        check("hit_cnt", bus.hit_cnt, exp_hit);
        next_cycle();
        bus.req_rd = 1'b0;
        bus.req_wr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int n;
        exp_rd_pulses = 0;
        exp_wr_pulses = 0;
        rd_pulses     = 0;
        wr_pulses     = 0;
        reset_dut();

        @(negedge clk);
        check("rst_err", bus.err, 0);
        check("rst_acc", bus.acc_cnt, 0);
        check("rst_hit", bus.hit_cnt, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_stall", bus.stall_pipe, 0);
        check("rst_pulse", {bus.mem_rd, bus.mem_wr}, 0);
        next_cycle();

        // read hit, write miss, read back
        do_access(1'b0, 16'h0010, 16'h0000, 0, 1, 1'b1);
        do_access(1'b1, 16'h2040, 16'hBEEF, 0, 4, 1'b0);
        do_access(1'b0, 16'h2040, 16'h0000, 1, 1, 1'b1);
        check("beef_read", bus.rd_data, 16'hBEEF);

        // randomized accesses over a small address window, idle gaps with
        // stray Done pulses that must be ignored
        for (int k = 0; k < 40; k++) begin
            bit          wr;
            int          lat;
            logic [15:0] a;
            wr  = 1'($urandom);
            lat = $urandom_range(1, 6);
            a   = 16'h0100 + 16'(2 * $urandom_range(0, 7));
            do_access(wr, a, 16'($urandom), $urandom_range(0, 2), lat,
                      (lat == 1) ? 1'b1 : 1'($urandom));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                bus.mem_done = 1'($urandom);
                bus.mem_hit  = 1'b1;
                @(negedge clk);
                check("idle_stall", bus.stall_pipe, 0);
                check("idle_nopulse", {bus.mem_rd, bus.mem_wr}, 0);
                next_cycle();
            end
            bus.mem_done = 1'b0;
            bus.mem_hit  = 1'b0;
        end
        check("acc_saturated", bus.acc_cnt, CMAX);
        check("hit_cnt_final", bus.hit_cnt, exp_hit);
        check("rd_pulse_count", rd_pulses, exp_rd_pulses);
        check("wr_pulse_count", wr_pulses, exp_wr_pulses);

        // illegal requests: both types, then a misaligned load
        for (int t = 0; t < 2; t++) begin
            reset_dut();
            bus.req_rd   = 1'b1;
            bus.req_wr   = (t == 0);
            bus.req_addr = (t == 0) ? 16'h0020 : 16'h0031;
            @(negedge clk);
            check("illegal_nopulse", {bus.mem_rd, bus.mem_wr}, 0);
            check("illegal_err_early", bus.err, 0);
            next_cycle();
            bus.req_rd = 1'b0;
            bus.req_wr = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("halt_err", bus.err, 1);
                check("halt_stall", bus.stall_pipe, 1);
                check("halt_nopulse", {bus.mem_rd, bus.mem_wr}, 0);
                next_cycle();
            end
            reset_dut();
            @(negedge clk);
            check("halt_rst_err", bus.err, 0);
            check("halt_rst_stall", bus.stall_pipe, 0);
            next_cycle();
        end

        // mem_err together with Done during WAIT: no counter/data update
        reset_dut();
        do_access(1'b0, 16'h0200, 16'h0000, 0, 1, 1'b1);
        bus.req_rd   = 1'b1;
        bus.req_addr = 16'h0202;
        next_cycle();
        bus.mem_err   = 1'b1;
        bus.mem_done  = 1'b1;
        bus.mem_hit   = 1'b1;
        bus.mem_rdata = 16'h1234;
        next_cycle();
        bus.mem_err  = 1'b0;
        bus.mem_done = 1'b0;
        @(negedge clk);
        check("memerr_err", bus.err, 1);
        check("memerr_stall", bus.stall_pipe, 1);
        check("memerr_acc", bus.acc_cnt, exp_acc);
        check("memerr_hit", bus.hit_cnt, exp_hit);
        check("memerr_rd_data", bus.rd_data, exp_rd);
        next_cycle();

        // watchdog: Done never comes
        reset_dut();
        bus.req_rd   = 1'b1;
        bus.req_addr = 16'h0300;
        @(negedge clk);
        check("wd_issue", bus.mem_rd, 1);
        next_cycle();
        n = 0;
        @(negedge clk);
        while (!bus.err && n < 200) begin
            n++;
            next_cycle();
            @(negedge clk);
        end
        check("wd_wait_cycles", n, TIMEOUT);
        check("wd_stall", bus.stall_pipe, 1);
        next_cycle();

        // reset in the middle of WAIT
        reset_dut();
        do_access(1'b0, 16'h0400, 16'h0000, 0, 2, 1'b1);
        bus.req_rd   = 1'b1;
        bus.req_addr = 16'h0402;
        next_cycle();
        rst        = 1'b1;
        bus.req_rd = 1'b0;
        next_cycle();
        rst     = 1'b0;
        exp_acc = 0;
        exp_hit = 0;
        exp_rd  = '0;
        @(negedge clk);
        check("midrst_stall", bus.stall_pipe, 0);
        check("midrst_acc", bus.acc_cnt, 0);
        check("midrst_rd_data", bus.rd_data, 0);
        check("midrst_err", bus.err, 0);
        next_cycle();
        do_access(1'b0, 16'h0010, 16'h0000, 0, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_req_ctrl.md
Name: dmem_req_ctrl

Overview:
- Pipeline-side request controller that sits directly upstream of the two-way set-associative mem_system in the MEM stage.
- Turns the level-held load/store request from the EX/MEM pipeline register into a single-cycle Rd/Wr pulse, then waits for Done.
- Latches the returned read data and generates the pipeline stall for the whole access.
- Also provides a sticky error (memory error, illegal request, watchdog timeout) and saturating access/hit counters for performance dumps.

Parameters:
TIMEOUT, 64, max cycles allowed in WAIT before a timeout error (range 8..255)
CNT_W, 16, width of the access and hit performance counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_rd  input  1  pipeline load request, held until stall_pipe deasserts
req_wr  input  1  pipeline store request, held until stall_pipe deasserts
req_addr  input  16  byte address; bit 0 must be 0
req_data  input  16  store data
mem_done  input  1  Done from mem_system
mem_stall  input  1  Stall from mem_system
mem_hit  input  1  CacheHit from mem_system
mem_rdata  input  16  DataOut from mem_system
mem_err  input  1  err from mem_system
mem_addr  output  16  Addr to mem_system
mem_wdata  output  16  DataIn to mem_system
mem_rd  output  1  Rd to mem_system
mem_wr  output  1  Wr to mem_system
rd_data  output  16  registered load result
stall_pipe  output  1  freeze all pipeline stages
err  output  1  sticky error flag
acc_cnt  output  CNT_W  completed accesses
hit_cnt  output  CNT_W  completed accesses that were cache hits

Behaviour:
- Reset (synchronous, rst high at clk edge) forces the following, regardless of state:
  - state=IDLE; rd_data=0; err=0; acc_cnt=0; hit_cnt=0; watchdog=0.
  - Internal addr and data registers = 0.
  - mem_rd=mem_wr=0.
- States: IDLE, WAIT, COMPLETE, HALT. Encoded in a 2-bit state register.
- IDLE:
  - mem_addr=req_addr and mem_wdata=req_data, driven combinationally.
  - If exactly one of req_rd/req_wr is high and mem_stall=0: drive mem_rd=req_rd, mem_wr=req_wr for this cycle only; latch addr, data and type; stall_pipe=1; go to WAIT.
  - If no request: stall_pipe=0, stay in IDLE.
  - If a request is pending but mem_stall=1: no pulse, stall_pipe=1, stay in IDLE.
  - If req_rd and req_wr are both high, or req_addr[0]=1 with a request present: set err=1, no pulse, go to HALT.
- WAIT:
  - mem_rd=mem_wr=0; mem_addr and mem_wdata driven from the latched registers; stall_pipe=1; watchdog increments each cycle.
  - On mem_done:
    - Loads: rd_data<=mem_rdata. Stores leave rd_data unchanged.
    - acc_cnt++; hit_cnt++ if mem_hit=1.
    - Clear watchdog; go to COMPLETE.
  - Both counters saturate at all-ones and never wrap.
- COMPLETE:
  - Lasts exactly one cycle. stall_pipe=0, so the pipeline advances at the end of this cycle.
  - No new request is issued, because req_* still shows the old request.
  - Go to IDLE.
- Latency: a cache hit (mem_done one cycle after the pulse) gives issue→COMPLETE in 3 cycles with stall_pipe high for 2 cycles. A miss adds the mem_system miss time.
- Errors:
  - mem_err high in any state except HALT → err=1, go to HALT. This takes priority over mem_done in the same cycle; counters are not updated.
  - Watchdog reaching TIMEOUT in WAIT → err=1, go to HALT.
- HALT: stall_pipe=1, mem_rd=mem_wr=0, err held at 1. Only rst exits HALT.
- mem_done seen outside WAIT is ignored.
- Reset mid-access: the controller returns to IDLE immediately. mem_system shares the same rst, so no orphaned access remains.

Test Plan:
- Read hit: preload a line; req_rd=1, addr=0x0010 → mem_rd pulses for 1 cycle with mem_addr=0x0010; stall_pipe=1,1,0; rd_data=preloaded value; acc_cnt=1, hit_cnt=1.
- Write miss then read hit: store 0xBEEF to 0x2040 (miss, mem_hit=0), then load 0x2040 → rd_data=0xBEEF; acc_cnt=2, hit_cnt=1; exactly one mem_wr pulse and one mem_rd pulse.
- Held request: keep req_rd high through COMPLETE → only one mem_rd pulse per request. Change req_addr during WAIT → mem_addr stays at the latched value.
- Illegal request: req_rd=req_wr=1 → err=1 next cycle, no pulse, stall_pipe stuck at 1 until rst, then err=0.
- Errors: mem_err=1 during WAIT → err=1, HALT, counters unchanged. mem_done never asserted → err=1 after 64 WAIT cycles.
- Saturation and reset: force acc_cnt to all-ones, complete an access → stays all-ones. Assert rst in WAIT → next cycle state=IDLE, all outputs at reset values.
